// File: rtl/sub_iter.sv
// Iterative signed/unsigned subtractor: computes A - B one SLICE-bit slice per cycle,
// LSB first, and publishes the difference plus borrow/overflow/zero flags on completion.
module sub_iter #(
    parameter int unsigned N     = 5,
    parameter int unsigned SLICE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         borrow,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned STEPS = N / SLICE;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned SW    = SLICE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           load;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   res_sh;
    logic [N-1:0]   res_next;
    logic           a_msb;
    logic           b_msb;
    logic           bin;
    logic [CW-1:0]  cnt;
    logic           last;
    logic [SW-1:0]  sdiff;

    // State register; busy/done are registered copies of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic; a new operation may be accepted from IDLE or DONE only
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Current slice difference (MSB is the slice borrow-out) and the partial result after it
    always_comb begin
        sdiff    = {1'b0, a_sh[SLICE-1:0]} - {1'b0, b_sh[SLICE-1:0]} - SW'(bin);
        res_next = (res_sh >> SLICE) | (N'(sdiff[SLICE-1:0]) << (N - SLICE));
        last     = (state == RUN) && (cnt == CW'(STEPS - 1));
    end

    // Operand shifters, borrow chain, partial result and published result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            bin    <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (load) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            a_msb  <= A[N-1];
            b_msb  <= B[N-1];
            bin    <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> SLICE;
            b_sh   <= b_sh >> SLICE;
            res_sh <= res_next;
            bin    <= sdiff[SLICE];
            cnt    <= cnt + CW'(1);
            if (last) begin
                out    <= res_next;
                borrow <= sdiff[SLICE];
                ovf    <= (a_msb != b_msb) && (res_next[N-1] != a_msb);
                zero   <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_sub_iter.sv
// Randomized scoreboard bench for sub_iter: one SLICE=1 instance and one SLICE=N instance.
module tb_sub_iter;

    localparam int N      = 5;
    localparam int STEPS1 = 5;
    localparam int STEPS5 = 1;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           cyc;
    } exp_t;

    typedef struct packed {
        logic [N-1:0] out;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start1 = 1'b0;
    logic [N-1:0] a1 = '0;
    logic [N-1:0] b1 = '0;
    logic         busy1, done1, borrow1, ovf1, zero1;
    logic [N-1:0] out1;
    logic         start5 = 1'b0;
    logic [N-1:0] a5 = '0;
    logic [N-1:0] b5 = '0;
    logic         busy5, done5, borrow5, ovf5, zero5;
    logic [N-1:0] out5;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb1[$];
    exp_t sb5[$];

    sub_iter #(.N(N), .SLICE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .out(out1), .borrow(borrow1), .ovf(ovf1), .zero(zero1)
    );

    sub_iter #(.N(N), .SLICE(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .A(a5), .B(b5),
        .busy(busy5), .done(done5), .out(out5), .borrow(borrow5), .ovf(ovf5), .zero(zero5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        res_t r;
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
        int   sb = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
        int   sd = sa - sb;
        r.out    = N'((ua - ub + 2 ** N) % (2 ** N));
        r.borrow = (ua < ub);
        r.ovf    = (sd < -(2 ** (N - 1))) || (sd > 2 ** (N - 1) - 1);
        r.zero   = (ua == ub);
        return r;
    endfunction

    // Monitor for the SLICE=1 instance
    int   run1 = 0;
    res_t prev1 = '0;
    exp_t e1;
    res_t r1;
    always @(posedge clk) begin
        #1;
        chk("busy_done_excl1", int'(busy1 && done1), 0);
        if (!done1 && !rst)
            chk("result_hold1", int'({out1, borrow1, ovf1, zero1}), int'(prev1));
        prev1 = {out1, borrow1, ovf1, zero1};
        if (done1) begin
            chk("busy_len1", run1, STEPS1);
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e1 = sb1.pop_front();
                r1 = model(e1.a, e1.b);
                chk("done_cycle1", cyc, e1.cyc);
                chk("out1", int'(out1), int'(r1.out));
                chk("borrow1", int'(borrow1), int'(r1.borrow));
                chk("ovf1", int'(ovf1), int'(r1.ovf));
                chk("zero1", int'(zero1), int'(r1.zero));
            end
        end
        if (busy1) run1++;
        else run1 = 0;
    end

    // Monitor for the SLICE=N instance
    exp_t e5;
    res_t r5;
    always @(posedge clk) begin
        #1;
        chk("busy_done_excl5", int'(busy5 && done5), 0);
        if (done5) begin
            if (sb5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done5: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e5 = sb5.pop_front();
                r5 = model(e5.a, e5.b);
                chk("done_cycle5", cyc, e5.cyc);
                chk("out5", int'(out5), int'(r5.out));
                chk("borrow5", int'(borrow5), int'(r5.borrow));
                chk("ovf5", int'(ovf5), int'(r5.ovf));
                chk("zero5", int'(zero5), int'(r5.zero));
            end
        end
    end

    // Called right after a negedge; returns right after the following negedge
    task automatic issue1(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        a1 = a; b1 = b; start1 = 1'b1;
        e.a = a; e.b = b; e.cyc = cyc + 1 + STEPS1;
        sb1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int gap,
                          input bit spur, input logic [N-1:0] sa, input logic [N-1:0] sbv);
        issue1(a, b);
        for (int i = 1; i <= STEPS1 + gap; i++) begin
            @(negedge clk);
            if (i == 1 && spur) begin
                a1 = sa; b1 = sbv; start1 = 1'b1;
            end
            if (i == 2) start1 = 1'b0;
        end
    endtask

    task automatic issue5(input logic [N-1:0] a, input logic [N-1:0] b, input int gap);
        exp_t e;
        a5 = a; b5 = b; start5 = 1'b1;
        e.a = a; e.b = b; e.cyc = cyc + 1 + STEPS5;
        sb5.push_back(e);
        @(negedge clk);
        start5 = 1'b0;
        repeat (STEPS5 + gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_out", int'(out1), 0);
        chk("rst_flags", int'({borrow1, ovf1, zero1}), 0);
        chk("rst_out5", int'({out5, borrow5, ovf5, zero5, busy5, done5}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(5'd7, 5'd3, 1, 1'b0, '0, '0);
        run_op(5'd3, 5'd7, 1, 1'b0, '0, '0);
        run_op(5'd16, 5'd1, 1, 1'b0, '0, '0);
        run_op(5'd9, 5'd9, 1, 1'b0, '0, '0);
        // Spurious start during RUN, then start held in the DONE cycle
        run_op(5'd7, 5'd3, 0, 1'b1, 5'd1, 5'd1);
        run_op(5'd2, 5'd5, 2, 1'b0, '0, '0);

        // Full-width slice instance
        issue5(5'd16, 5'd1, 1);
        issue5(5'd0, 5'd0, 0);
        for (int i = 0; i < 10; i++)
            issue5(N'($urandom), N'($urandom), int'($urandom_range(0, 2)));

        // Randomized operations with random gaps and spurious starts
        for (int i = 0; i < 60; i++)
            run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), N'($urandom), N'($urandom));

        // Reset in the third RUN cycle discards the operation
        run_op(5'd2, 5'd5, 1, 1'b0, '0, '0);
        issue1(5'd7, 5'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb1.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_busy", int'(busy1), 0);
        chk("mid_rst_out", int'(out1), 0);
        chk("mid_rst_flags", int'({borrow1, ovf1, zero1, done1}), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", int'(done1), 0);
        end

        repeat (4) @(negedge clk);
        chk("sb1_drained", sb1.size(), 0);
        chk("sb5_drained", sb5.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
